// File: rtl/config_loader.sv
// config_loader: converts a valid/ready word stream into the serial
// hard-config protocol (shift_in / cen / cset) of a tile's config chain.
// Words are shifted LSB first, exactly CHAIN_LEN bits per load, followed by
// a single cset pulse and a single done pulse.
// Build option: define CONFIG_LOADER_CRC_EN to append a CRC-8 check word
// (poly 0x07, init 0x00) after the data; a mismatch aborts with err set.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; chain outputs quiet
// S_SHIFT | accepting words and shifting one bit per cycle when fed
// S_SET   | last data bit is on the wire (cen=1); cset follows next cycle
// S_CHECK | last data bit is on the wire; waiting for the CRC word
// S_DONE  | cset is on the wire; done follows next cycle
// Outputs are registered, so each state shows the action chosen on the
// previous edge; cset therefore lands on the cycle right after the final cen.
module config_loader #(
  parameter int WORD_WIDTH = 32,
  parameter int CHAIN_LEN  = 132,
  parameter int CNT_WIDTH  = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  shift_in,
  output logic                  cen,
  output logic                  cset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NWORDS    = (CHAIN_LEN + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_WIDTH;
  localparam int HC_WIDTH  = $clog2(WORD_WIDTH + 1);
  localparam int WC_WIDTH  = $clog2(NWORDS + 1);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX   = CNT_WIDTH'(CHAIN_LEN - 1);
  localparam logic [HC_WIDTH-1:0]  FULL_CNT   = HC_WIDTH'(WORD_WIDTH);
  localparam logic [HC_WIDTH-1:0]  TAIL_CNT   = HC_WIDTH'(LAST_BITS);
  localparam logic [HC_WIDTH-1:0]  ONE_CNT    = HC_WIDTH'(1);
  localparam logic [WC_WIDTH-1:0]  WORDS_MAX  = WC_WIDTH'(NWORDS);
  localparam logic [WC_WIDTH-1:0]  WORDS_LAST = WC_WIDTH'(NWORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_SET,
`ifdef CONFIG_LOADER_CRC_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t                state_q;
  logic [WORD_WIDTH-1:0] hold_q;
  logic [HC_WIDTH-1:0]   hold_cnt_q;
  logic [HC_WIDTH-1:0]   hold_cnt_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q;
  logic [WC_WIDTH-1:0]   words_q;
  logic                  shift_in_q;
  logic                  cen_q;
  logic                  cset_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  shifting;
  logic                  accept;
  logic                  crc_ok;
  state_t                after_data;

  assign shifting   = (hold_cnt_q != '0);
  assign accept     = word_valid && word_ready;
  // The final word only carries the bits still missing from the chain.
  assign hold_cnt_d = (words_q == WORDS_LAST) ? TAIL_CNT : FULL_CNT;

  // Ready when the holding register is empty or about to empty this cycle,
  // so a continuous stream keeps cen high without bubbles.
  always_comb begin
    word_ready = 1'b0;
    if (!abort) begin
      if (state_q == S_SHIFT) begin
        word_ready = (hold_cnt_q <= ONE_CNT) && (words_q < WORDS_MAX);
      end
`ifdef CONFIG_LOADER_CRC_EN
      else if (state_q == S_CHECK) begin
        word_ready = 1'b1;
      end
`endif
    end
  end

`ifdef CONFIG_LOADER_CRC_EN
  logic [7:0] crc_q;
  logic       crc_fb;
  logic       err_q;

  assign crc_fb     = crc_q[7] ^ hold_q[0];
  assign crc_ok     = (word_data[7:0] == crc_q);
  assign after_data = S_CHECK;
  assign err        = err_q;

  // Running CRC-8 over every bit that actually goes out on the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= 8'h00;
    end else if (state_q == S_IDLE && start) begin
      crc_q <= 8'h00;
    end else if (state_q == S_SHIFT && !abort && shifting) begin
      crc_q <= {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
    end
  end

  // Sticky CRC failure flag, cleared only by the next accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      err_q <= 1'b0;
    end else if (state_q == S_CHECK && !abort && accept && !crc_ok) begin
      err_q <= 1'b1;
    end
  end
`else
  assign crc_ok     = 1'b1;
  assign after_data = S_SET;
  assign err        = 1'b0;
`endif

  // Sequencer: word intake, serialisation, latch pulse and completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      bit_cnt_q  <= '0;
      words_q    <= '0;
      shift_in_q <= 1'b0;
      cen_q      <= 1'b0;
      cset_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cset_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cen_q  <= 1'b0;
          busy_q <= start;
          if (start) begin
            state_q    <= S_SHIFT;
            bit_cnt_q  <= '0;
            words_q    <= '0;
            hold_cnt_q <= '0;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            state_q    <= S_IDLE;
            cen_q      <= 1'b0;
            busy_q     <= 1'b0;
            hold_q     <= '0;
            hold_cnt_q <= '0;
          end else begin
            cen_q <= shifting;
            if (shifting) begin
              shift_in_q <= hold_q[0];
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == LAST_IDX) begin
                state_q <= after_data;
              end
            end
            if (accept) begin
              hold_q     <= word_data;
              hold_cnt_q <= hold_cnt_d;
              words_q    <= words_q + 1'b1;
            end else if (shifting) begin
              hold_q     <= hold_q >> 1;
              hold_cnt_q <= hold_cnt_q - 1'b1;
            end
          end
        end
`ifdef CONFIG_LOADER_CRC_EN
        S_CHECK: begin
          cen_q <= 1'b0;
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (accept) begin
            if (crc_ok) begin
              cset_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
`endif
        S_SET: begin
          cen_q   <= 1'b0;
          cset_q  <= crc_ok;
          state_q <= S_DONE;
        end
        S_DONE: begin
          cen_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          cen_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign shift_in = shift_in_q;
  assign cen      = cen_q;
  assign cset     = cset_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
